// File: rtl/alu_defs_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM state
// encoding and the bit positions of the flag vector held beside the result.
// Imported by seq_alu and seq_alu_mul.
package alu_defs_pkg;

    // Opcode values. Decode compares against these after casting to the
    // configured opcode width.
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADDR = 5'd1;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_SUBR = 5'd3;
    localparam logic [4:0] OP_SUBI = 5'd4;
    localparam logic [4:0] OP_INC  = 5'd5;
    localparam logic [4:0] OP_DEC  = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_SR   = 5'd11;
    localparam logic [4:0] OP_SL   = 5'd12;
    localparam logic [4:0] OP_RR   = 5'd13;
    localparam logic [4:0] OP_RL   = 5'd14;
    localparam logic [4:0] OP_LDI  = 5'd15;
    localparam logic [4:0] OP_LDR  = 5'd16;
    localparam logic [4:0] OP_MUL  = 5'd17;
    localparam logic [4:0] OP_SRAN = 5'd18;
    localparam logic [4:0] OP_SLLN = 5'd19;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flag vector bit positions.
    localparam int FLAG_Z  = 0;   // result == 0
    localparam int FLAG_LT = 1;   // result < 0
    localparam int FLAG_GT = 2;   // result > 0
    localparam int FLAG_C  = 3;   // carry / borrow / shifted-out bit
    localparam int FLAG_V  = 4;   // signed overflow
    localparam int FLAG_W  = 5;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative signed multiplier: shift-add on operand magnitudes, one multiplier
// bit per cycle, two's-complement negate of the final product if signs differ.
// Ports: clk/rst_n, start_i loads a_i/b_i; done_o is high in the cycle whose
// rising edge completes the last step, and prod_o then carries the final
// signed 2*DATA_WIDTH product (valid only while done_o is high).
module seq_alu_mul
    import alu_defs_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      done_o,
    output logic [2*DATA_WIDTH-1:0]   prod_o
);

    localparam int N     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [N-1:0]     ONE_N  = N'(1);
    localparam logic [2*N-1:0]   ONE_2N = (2*N)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic             neg_q, neg_d;

    logic [N-1:0]     mag_a, mag_b;
    logic [2*N-1:0]   acc_nxt;

    // Magnitudes are unsigned N-bit, so the most-negative operand maps to
    // 2^(N-1) without overflow.
    always_comb begin
        mag_a = a_i[N-1] ? (~a_i + ONE_N) : a_i;
        mag_b = b_i[N-1] ? (~b_i + ONE_N) : b_i;
    end

    // Accumulator value after the step taken this cycle; the final product is
    // produced from it so the result is ready on the same edge the count ends.
    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_o  = neg_q ? (~acc_nxt + ONE_2N) : acc_nxt;
    assign done_o  = (cnt_q == CNT_ONE);

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        if (start_i) begin
            cnt_d    = CNT_W'(DATA_WIDTH);
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = a_i[N-1] ^ b_i[N-1];
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CNT_ONE;
            acc_d    = acc_nxt;
            mcand_d  = {mcand_q[2*N-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes; one operation in flight.
// Ports: in_valid/in_ready/op/in1_acc/in2_reg accept an op; out_valid/out_ready
// hand over data_out, data_hi (MUL high half) and zero/lt/gt/carry/ovf flags.
// Latency 1 cycle for single-cycle ops, DATA_WIDTH+1 for MUL; results are held
// until out_ready, and a new op may be accepted in the same cycle.
module seq_alu
    import alu_defs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 5,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] in1_acc,
    input  logic [DATA_WIDTH-1:0] in2_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] data_hi,
    output logic                  zero_f,
    output logic                  ls_z_f,
    output logic                  gr_z_f,
    output logic                  carry_f,
    output logic                  ovf_f
);

    localparam int N = DATA_WIDTH;
    localparam logic [N-1:0]       ONE_N     = N'(1);
    localparam logic [SHAMT_W-1:0] SHAMT_ONE = SHAMT_W'(1);

    state_e              state_q, state_d;
    logic [N-1:0]        dout_q, dout_d;
    logic [N-1:0]        dhi_q, dhi_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic                load_op;
    logic                is_mul;
    logic                mul_start;
    logic                mul_done;
    logic [2*N-1:0]      mul_prod;
    logic [FLAG_W-1:0]   mul_flags;

    logic [N-1:0]        alu_res;
    logic [FLAG_W-1:0]   alu_flags;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the operands being accepted.
    // ------------------------------------------------------------------
    logic [N-1:0]        add_b, sub_b;
    logic [N:0]          sum, diff;
    logic [SHAMT_W-1:0]  amt, amt_m1;
    logic [N-1:0]        sh_tmp;
    logic                c_bit, v_bit;

    always_comb begin
        add_b   = (op == OP_WIDTH'(OP_INC)) ? ONE_N : in2_reg;
        sub_b   = (op == OP_WIDTH'(OP_DEC)) ? ONE_N : in2_reg;
        sum     = {1'b0, in1_acc} + {1'b0, add_b};
        diff    = {1'b0, in1_acc} - {1'b0, sub_b};
        amt     = in2_reg[SHAMT_W-1:0];
        amt_m1  = amt - SHAMT_ONE;
        sh_tmp  = '0;
        alu_res = in1_acc;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        case (op)
            OP_WIDTH'(OP_ADDR), OP_WIDTH'(OP_ADDI), OP_WIDTH'(OP_INC): begin
                alu_res = sum[N-1:0];
                c_bit   = sum[N];
                v_bit   = (in1_acc[N-1] == add_b[N-1]) && (sum[N-1] != in1_acc[N-1]);
            end
            OP_WIDTH'(OP_SUBR), OP_WIDTH'(OP_SUBI), OP_WIDTH'(OP_DEC): begin
                alu_res = diff[N-1:0];
                c_bit   = diff[N];   // borrow out equals unsigned in1 < in2
                v_bit   = (in1_acc[N-1] != sub_b[N-1]) && (diff[N-1] != in1_acc[N-1]);
            end
            OP_WIDTH'(OP_XOR): alu_res = in1_acc ^ in2_reg;
            OP_WIDTH'(OP_OR):  alu_res = in1_acc | in2_reg;
            OP_WIDTH'(OP_AND): alu_res = in1_acc & in2_reg;
            OP_WIDTH'(OP_NOT): alu_res = ~in1_acc;
            OP_WIDTH'(OP_SR): begin
                alu_res = {in1_acc[N-1], in1_acc[N-1:1]};
                c_bit   = in1_acc[0];
            end
            OP_WIDTH'(OP_SL): begin
                alu_res = {in1_acc[N-2:0], 1'b0};
                c_bit   = in1_acc[N-1];
                v_bit   = in1_acc[N-1] ^ in1_acc[N-2];
            end
            OP_WIDTH'(OP_RR): alu_res = {in1_acc[0], in1_acc[N-1:1]};
            OP_WIDTH'(OP_RL): alu_res = {in1_acc[N-2:0], in1_acc[N-1]};
            OP_WIDTH'(OP_SRAN): begin
                alu_res = N'($signed(in1_acc) >>> amt);
                // Last bit out is in1[amt-1]; shift so it lands at bit 0.
                sh_tmp  = in1_acc >> amt_m1;
                c_bit   = (amt != '0) && sh_tmp[0];
            end
            OP_WIDTH'(OP_SLLN): begin
                alu_res = in1_acc << amt;
                // Last bit out is in1[N-amt]; shift so it lands at the MSB.
                sh_tmp  = in1_acc << amt_m1;
                c_bit   = (amt != '0) && sh_tmp[N-1];
            end
            OP_WIDTH'(OP_LDI), OP_WIDTH'(OP_LDR): alu_res = in2_reg;
            default: alu_res = in1_acc;   // NOP and unassigned opcodes
        endcase

        alu_flags          = '0;
        alu_flags[FLAG_Z]  = (alu_res == '0);
        alu_flags[FLAG_LT] = alu_res[N-1];
        alu_flags[FLAG_GT] = (alu_res != '0) && !alu_res[N-1];
        alu_flags[FLAG_C]  = c_bit;
        alu_flags[FLAG_V]  = v_bit;
    end

    // Product flags are judged on the full double-width value; overflow means
    // the high half is not a pure sign extension of the low half.
    always_comb begin
        mul_flags          = '0;
        mul_flags[FLAG_Z]  = (mul_prod == '0);
        mul_flags[FLAG_LT] = mul_prod[2*N-1];
        mul_flags[FLAG_GT] = (mul_prod != '0) && !mul_prod[2*N-1];
        mul_flags[FLAG_V]  = (mul_prod[2*N-1:N] != {N{mul_prod[N-1]}});
    end

    assign is_mul    = (op == OP_WIDTH'(OP_MUL));
    assign mul_start = load_op && is_mul;

    seq_alu_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (in1_acc),
        .b_i     (in2_reg),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        dhi_d     = dhi_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_op   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                load_op  = in_valid;
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    dout_d  = mul_prod[N-1:0];
                    dhi_d   = mul_prod[2*N-1:N];
                    flags_d = mul_flags;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Consuming the result frees the unit for a back-to-back op.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_op = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_op) begin
            if (is_mul) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_DONE;
                dout_d  = alu_res;
                dhi_d   = '0;
                flags_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            dhi_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            dhi_q   <= dhi_d;
            flags_q <= flags_d;
        end
    end

    assign data_out = dout_q;
    assign data_hi  = dhi_q;
    assign zero_f   = flags_q[FLAG_Z];
    assign ls_z_f   = flags_q[FLAG_LT];
    assign gr_z_f   = flags_q[FLAG_GT];
    assign carry_f  = flags_q[FLAG_C];
    assign ovf_f    = flags_q[FLAG_V];

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at DATA_WIDTH=8.
// Expected flags are written {ovf, carry, gt, lt, zero}.
module tb_seq_alu;
    import alu_defs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] op = 5'd0;
    logic [7:0] in1_acc = 8'd0;
    logic [7:0] in2_reg = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    logic [7:0] data_hi;
    logic       zero_f, ls_z_f, gr_z_f, carry_f, ovf_f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .DATA_WIDTH (8),
        .OP_WIDTH   (5),
        .SHAMT_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1_acc   (in1_acc),
        .in2_reg   (in2_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .data_hi   (data_hi),
        .zero_f    (zero_f),
        .ls_z_f    (ls_z_f),
        .gr_z_f    (gr_z_f),
        .carry_f   (carry_f),
        .ovf_f     (ovf_f)
    );

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [4:0] fl;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [4:0] o, logic [7:0] a, logic [7:0] b,
                                logic [7:0] lo, logic [7:0] hi, logic [4:0] fl, int lat);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b;
        v.lo = lo; v.hi = hi; v.fl = fl; v.lat = lat;
        return v;
    endfunction

    function automatic logic [4:0] flags_now();
        return {ovf_f, carry_f, gr_z_f, ls_z_f, zero_f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one op from IDLE, scramble the inputs after accept, wait for the
    // result with a bounded cycle count, check it, then consume it.
    task automatic run_op(input vec_t v);
        int   cyc;
        logic got;
        @(negedge clk);
        chk({v.name, ":in_ready"}, 32'(in_ready), 32'd1);
        op = v.op; in1_acc = v.a; in2_reg = v.b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = OP_NOT; in1_acc = ~v.a; in2_reg = ~v.b;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1'b1;
            else chk({v.name, ":busy_in_ready"}, 32'(in_ready), 32'd0);
        end
        chk({v.name, ":latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(v.lat));
        if (got) begin
            chk({v.name, ":data_out"}, 32'(data_out), 32'(v.lo));
            chk({v.name, ":data_hi"},  32'(data_hi),  32'(v.hi));
            chk({v.name, ":flags"},    32'(flags_now()), 32'(v.fl));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int   quiet;
        logic stray;

        //              name          op       a      b      lo     hi     {v,c,g,l,z} lat
        vecs.push_back(mk("add_ovf",   OP_ADDR, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b10010, 1));
        vecs.push_back(mk("sub_borrow",OP_SUBR, 8'h00, 8'h01, 8'hFF, 8'h00, 5'b01010, 1));
        vecs.push_back(mk("inc_wrap",  OP_INC,  8'hFF, 8'h00, 8'h00, 8'h00, 5'b01001, 1));
        vecs.push_back(mk("mul_m3x5",  OP_MUL,  8'hFD, 8'h05, 8'hF1, 8'hFF, 5'b00010, 9));
        vecs.push_back(mk("mul_minsq", OP_MUL,  8'h80, 8'h80, 8'h00, 8'h40, 5'b10100, 9));
        vecs.push_back(mk("sran3",     OP_SRAN, 8'h80, 8'h03, 8'hF0, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("slln1",     OP_SLLN, 8'h81, 8'h01, 8'h02, 8'h00, 5'b01100, 1));
        vecs.push_back(mk("sran0",     OP_SRAN, 8'h5A, 8'h08, 8'h5A, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("sub_ovf",   OP_SUBR, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b10100, 1));
        vecs.push_back(mk("xor",       OP_XOR,  8'hF0, 8'hFF, 8'h0F, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("and",       OP_AND,  8'hC3, 8'h0F, 8'h03, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("or",        OP_OR,   8'h50, 8'h05, 8'h55, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("not",       OP_NOT,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("sl_carry",  OP_SL,   8'hC0, 8'h00, 8'h80, 8'h00, 5'b01010, 1));
        vecs.push_back(mk("sl_ovf",    OP_SL,   8'h40, 8'h00, 8'h80, 8'h00, 5'b10010, 1));
        vecs.push_back(mk("sr",        OP_SR,   8'h81, 8'h00, 8'hC0, 8'h00, 5'b01010, 1));
        vecs.push_back(mk("rr",        OP_RR,   8'h01, 8'h00, 8'h80, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("rl",        OP_RL,   8'h80, 8'h00, 8'h01, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("dec_wrap",  OP_DEC,  8'h00, 8'h00, 8'hFF, 8'h00, 5'b01010, 1));
        vecs.push_back(mk("ldi",       OP_LDI,  8'h55, 8'h33, 8'h33, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("ldr_zero",  OP_LDR,  8'h55, 8'h00, 8'h00, 8'h00, 5'b00001, 1));
        vecs.push_back(mk("mul_zero",  OP_MUL,  8'h00, 8'h7F, 8'h00, 8'h00, 5'b00001, 9));
        vecs.push_back(mk("mul_maxsq", OP_MUL,  8'h7F, 8'h7F, 8'h01, 8'h3F, 5'b10100, 9));
        vecs.push_back(mk("mul_neg",   OP_MUL,  8'h81, 8'h02, 8'h02, 8'hFF, 5'b10010, 9));
        vecs.push_back(mk("unlisted",  5'h1F,   8'h12, 8'h34, 8'h12, 8'h00, 5'b00100, 1));
        vecs.push_back(mk("addi_wrap", OP_ADDI, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b01001, 1));
        vecs.push_back(mk("slln7",     OP_SLLN, 8'h01, 8'h07, 8'h80, 8'h00, 5'b00010, 1));
        vecs.push_back(mk("sran7",     OP_SRAN, 8'hC0, 8'h07, 8'hFF, 8'h00, 5'b01010, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:in_ready",  32'(in_ready),  32'd1);
        chk("reset:data_out",  32'(data_out),  32'd0);
        chk("reset:data_hi",   32'(data_hi),   32'd0);
        chk("reset:flags",     32'(flags_now()), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: hold the result, then consume and accept together.
        @(negedge clk);
        op = OP_ADDR; in1_acc = 8'h10; in2_reg = 8'h20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp:first_valid", 32'(out_valid), 32'd1);
        chk("bp:first_data",  32'(data_out),  32'h30);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp:hold_valid",    32'(out_valid), 32'd1);
            chk("bp:hold_data",     32'(data_out),  32'h30);
            chk("bp:hold_flags",    32'(flags_now()), 32'b00100);
            chk("bp:hold_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        op = OP_ADDR; in1_acc = 8'h01; in2_reg = 8'h02; in_valid = 1'b1;
        #1;
        chk("bp:in_ready_follows", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp:b2b_valid", 32'(out_valid), 32'd1);
        chk("bp:b2b_data",  32'(data_out),  32'h03);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while a multiply is in progress.
        @(negedge clk);
        op = OP_MUL; in1_acc = 8'h7F; in2_reg = 8'h7F; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy:pre_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy:out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy:in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy:data_out",  32'(data_out),  32'd0);
        chk("rst_busy:data_hi",   32'(data_hi),   32'd0);
        chk("rst_busy:flags",     32'(flags_now()), 32'd0);
        stray = 1'b0;
        for (quiet = 0; quiet < 12; quiet++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        chk("rst_busy:no_stale_result", 32'(stray), 32'd0);
        run_op(mk("post_rst_add", OP_ADDR, 8'h05, 8'h03, 8'h08, 8'h00, 5'b00100, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
